rx_pkt_commit_fifo: RTL and testbench

//  Packet-granular receive FIFO controller between the radio receive path (wireless control) and the single-port SRAM.

---
 rtl/rx_pkt_commit_fifo_pkg.sv | 22 ++
 rtl/rx_pkt_commit_fifo_arbiter.sv | 61 ++++++
 rtl/rx_pkt_commit_fifo.sv | 171 +++++++++++++++++
 tb/tb_rx_pkt_commit_fifo.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_commit_fifo_pkg.sv
// Shared definitions for the packet-commit receive FIFO: FSM states,
// memory-port grant codes and parameter defaults.
package rx_pkt_commit_fifo_pkg;

   localparam int unsigned DEF_ADDR_W   = 18;
   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_AFULL_TH = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IN_PKT = 2'd1,
      ST_HDR_WR = 2'd2
   } fifo_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_HDR  = 2'd1,
      GNT_DATA = 2'd2,
      GNT_READ = 2'd3
   } mem_grant_t;

endpackage

// File: rtl/rx_pkt_commit_fifo_arbiter.sv
// Single-port SRAM arbiter: header write > data write > read, one access
// per cycle, plus the one-cycle mem_re -> rd_valid pipeline.
module rx_mem_arbiter
   import rx_pkt_commit_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hdr_req,
   input  logic [ADDR_W-1:0] hdr_addr,
   input  logic [DATA_W-1:0] hdr_data,
   input  logic              dat_req,
   input  logic [ADDR_W-1:0] dat_addr,
   input  logic [DATA_W-1:0] dat_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output mem_grant_t        grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   // Fixed-priority grant and memory port drive
   always_comb begin
      grant     = GNT_NONE;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (hdr_req) begin
         grant     = GNT_HDR;
         mem_addr  = hdr_addr;
         mem_wdata = hdr_data;
         mem_we    = 1'b1;
      end else if (dat_req) begin
         grant     = GNT_DATA;
         mem_addr  = dat_addr;
         mem_wdata = dat_data;
         mem_we    = 1'b1;
      end else if (rd_req) begin
         grant    = GNT_READ;
         mem_addr = rd_addr;
         mem_re   = 1'b1;
      end
   end

   // SRAM read data arrives the cycle after the strobe
   always_ff @(posedge clk) begin
      if (rst) rd_valid <= 1'b0;
      else     rd_valid <= mem_re;
   end

   assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: rtl/rx_pkt_commit_fifo.sv
// Packet-granular receive FIFO controller. Words are written speculatively
// and become visible to the reader only on commit; abort rolls back.
// Optional length header slot: define PKT_LEN_HEADER_EN.
module rx_pkt_commit_fifo
   import rx_pkt_commit_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned AFULL_TH = DEF_AFULL_TH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_start,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_commit,
   input  logic              wr_abort,
   output logic              wr_busy,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   commit_count,
   output logic              pkt_avail,
   output logic              ovf_drop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef PKT_LEN_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   fifo_state_t     state, state_nx;
   mem_grant_t      grant;
   logic [PW-1:0]   wr_spec_ptr, wr_cmt_ptr, rd_ptr, hdr_ptr, hdr_len;
   logic [PW-1:0]   spec_cnt, cmt_cnt, free_cnt;
   logic            ovf;
   logic            in_pkt, start, do_abort, do_commit, data_wr, ovf_set;
   logic            commit_ovf, res_full;

   assign spec_cnt     = wr_spec_ptr - rd_ptr;
   assign cmt_cnt      = wr_cmt_ptr - rd_ptr;
   assign free_cnt     = PW'(DEPTH) - spec_cnt;
   assign commit_count = cmt_cnt;
   assign empty        = (cmt_cnt == '0);
   assign full         = (spec_cnt == PW'(DEPTH));
   assign almost_full  = (32'(free_cnt) <= AFULL_TH);
   assign res_full     = (cmt_cnt == PW'(DEPTH));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; wr_start inside a packet restarts it in place
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (wr_start) state_nx = ST_IN_PKT;
         ST_IN_PKT: begin
            if (wr_start)       state_nx = ST_IN_PKT;
            else if (wr_abort)  state_nx = ST_IDLE;
            else if (wr_commit) state_nx = (HDR_EN && !commit_ovf) ? ST_HDR_WR : ST_IDLE;
         end
         ST_HDR_WR: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Write-side event decode; abort outranks commit, overflow turns commit into a drop
   always_comb begin
      in_pkt     = (state == ST_IN_PKT);
      start      = wr_start && (state != ST_HDR_WR);
      do_abort   = in_pkt && (wr_abort || wr_start);
      do_commit  = in_pkt && wr_commit && !wr_abort && !wr_start;
      data_wr    = in_pkt && wr_en && !full && !ovf && !wr_abort && !wr_start;
      ovf_set    = in_pkt && wr_en && full && !wr_abort && !wr_start;
      commit_ovf = do_commit && (ovf || ovf_set);
`ifdef PKT_LEN_HEADER_EN
      wr_busy    = (state == ST_HDR_WR);
`else
      wr_busy    = 1'b0;
`endif
   end

   // Pointer, overflow and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_spec_ptr <= '0;
         wr_cmt_ptr  <= '0;
         rd_ptr      <= '0;
         hdr_ptr     <= '0;
         hdr_len     <= '0;
         ovf         <= 1'b0;
         pkt_avail   <= 1'b0;
         ovf_drop    <= 1'b0;
      end else begin
         pkt_avail <= 1'b0;
         ovf_drop  <= 1'b0;
         // Later assignments override earlier ones: restart after implicit abort,
         // and an overflowed commit discards any word written this cycle.
         if (do_abort) begin
            wr_spec_ptr <= wr_cmt_ptr;
            ovf         <= 1'b0;
         end
         if (start) begin
            ovf <= 1'b0;
            if (HDR_EN) begin
               if (res_full) begin
                  ovf <= 1'b1;
               end else begin
                  hdr_ptr     <= wr_cmt_ptr;
                  wr_spec_ptr <= wr_cmt_ptr + PW'(1);
               end
            end
         end
         if (data_wr) wr_spec_ptr <= wr_spec_ptr + PW'(1);
         if (ovf_set) ovf <= 1'b1;
         if (do_commit) begin
            if (commit_ovf) begin
               wr_spec_ptr <= wr_cmt_ptr;
               ovf         <= 1'b0;
               ovf_drop    <= 1'b1;
            end else if (HDR_EN) begin
               hdr_len <= wr_spec_ptr + PW'(data_wr) - hdr_ptr - PW'(1);
            end else begin
               wr_cmt_ptr <= wr_spec_ptr + PW'(data_wr);
               if ((wr_spec_ptr + PW'(data_wr)) != wr_cmt_ptr) pkt_avail <= 1'b1;
            end
         end
         if (state == ST_HDR_WR) begin
            wr_cmt_ptr <= wr_spec_ptr;
            pkt_avail  <= 1'b1;
         end
         if (grant == GNT_READ) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   rx_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .hdr_req   (state == ST_HDR_WR),
      .hdr_addr  (hdr_ptr[ADDR_W-1:0]),
      .hdr_data  (DATA_W'(hdr_len)),
      .dat_req   (data_wr),
      .dat_addr  (wr_spec_ptr[ADDR_W-1:0]),
      .dat_data  (wr_data),
      .rd_req    (rd_req && !empty),
      .rd_addr   (rd_ptr[ADDR_W-1:0]),
      .mem_rdata (mem_rdata),
      .grant     (grant),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data)
   );

endmodule

// File: tb/tb_rx_pkt_commit_fifo.sv
// Scoreboard bench for rx_pkt_commit_fifo (ADDR_W=4). Committed packets are
// pushed into an expected-word queue; a monitor pops on every rd_valid.
module tb_rx_pkt_commit_fifo;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 16;
   localparam int          DEPTH = 16;
`ifdef PKT_LEN_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clk, rst;
   logic          wr_start, wr_en, wr_commit, wr_abort, wr_busy;
   logic [DW-1:0] wr_data;
   logic          rd_req, rd_valid;
   logic [DW-1:0] rd_data;
   logic          empty, full, almost_full, pkt_avail, ovf_drop;
   logic [AW:0]   commit_count;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we, mem_re;

   logic [DW-1:0] sram [0:DEPTH-1];

   int            tests = 0, fails = 0;
   int            n_pulse = 0, exp_pulse = 0, n_ovf = 0, exp_ovf = 0;
   logic [DW-1:0] exp_q[$];
   bit            rd_force = 0, rd_rand = 0;

   rx_pkt_commit_fifo #(.ADDR_W(AW), .DATA_W(DW), .AFULL_TH(4)) dut (
      .clk(clk), .rst(rst),
      .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data),
      .wr_commit(wr_commit), .wr_abort(wr_abort), .wr_busy(wr_busy),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .empty(empty), .full(full), .almost_full(almost_full),
      .commit_count(commit_count), .pkt_avail(pkt_avail), .ovf_drop(ovf_drop),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: compare every delivered word with the scoreboard, count pulses
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pkt_avail) n_pulse++;
            if (ovf_drop)  n_ovf++;
            if (rd_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, expected no word", rd_data);
               end else begin
                  chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // Reader: forced or random requests
   initial begin
      rd_req = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         rd_req = rd_force | (rd_rand & ($urandom_range(0, 1) == 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wr_start = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr();
      step(); step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // act: 0 commit, 1 abort, 2 commit+abort together
   task automatic send_pkt(input int n, input logic [DW-1:0] first, input bit rnd, input int act);
      logic [DW-1:0] pl[$];
      logic [DW-1:0] w;
      step(); clr(); wr_start = 1'b1;
      for (int i = 0; i < n; i++) begin
         step(); clr();
         if (rnd) while ($urandom_range(0, 3) == 0) step();
         w = rnd ? DW'($urandom) : first + DW'(i);
         wr_en = 1'b1; wr_data = w;
         pl.push_back(w);
      end
      step(); clr();
      wr_commit = (act != 1);
      wr_abort  = (act != 0);
      step(); clr();
      if (act == 0 && (n > 0 || HDR == 1)) begin
         if (HDR == 1) exp_q.push_back(DW'(n));
         foreach (pl[i]) exp_q.push_back(pl[i]);
         exp_pulse++;
      end
   endtask

   task automatic drain();
      int k = 0;
      rd_force = 1'b1;
      while (exp_q.size() > 0 && k < 300) begin
         step();
         k++;
      end
      rd_force = 1'b0;
      step(); step();
      chk("drain_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int n, r, k;
      rst = 1'b1; wr_data = '0; clr();
      do_reset();
      @(negedge clk);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_count", 32'(commit_count), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_pkt_avail", 32'(pkt_avail), 0);
      chk("rst_ovf_drop", 32'(ovf_drop), 0);
      chk("rst_wr_busy", 32'(wr_busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_re", 32'(mem_re), 0);

      // Four-word packet
      send_pkt(4, 16'h1111, 1'b0, 0);
      @(negedge clk);
`ifdef PKT_LEN_HEADER_EN
      chk("hdr_busy", 32'(wr_busy), 1);
      chk("hdr_we", 32'(mem_we), 1);
      chk("hdr_addr", 32'(mem_addr), 0);
      chk("hdr_len", 32'(mem_wdata), 4);
      chk("hdr_no_pulse_yet", 32'(pkt_avail), 0);
      step();
      @(negedge clk);
`endif
      chk("a_pkt_avail", 32'(pkt_avail), 1);
      chk("a_count", 32'(commit_count), 4 + HDR);
      chk("a_busy_low", 32'(wr_busy), 0);
      step();
      @(negedge clk);
      chk("a_pulse_1cyc", 32'(pkt_avail), 0);
      drain();

      // Abort then commit
      send_pkt(3, 16'h0300, 1'b0, 1);
      @(negedge clk);
      chk("b_abort_pulse", 32'(pkt_avail), 0);
      chk("b_abort_count", 32'(commit_count), 0);
      send_pkt(2, 16'h00A0, 1'b0, 0);
`ifdef PKT_LEN_HEADER_EN
      step();
`endif
      @(negedge clk);
      chk("b_count", 32'(commit_count), 2 + HDR);
      drain();

      // commit+abort same cycle keeps earlier committed data untouched
      send_pkt(3, 16'h0C00, 1'b0, 0);
`ifdef PKT_LEN_HEADER_EN
      step();
`endif
      send_pkt(2, 16'h0CC0, 1'b0, 2);
      @(negedge clk);
      chk("c_pulse", 32'(pkt_avail), 0);
      chk("c_busy", 32'(wr_busy), 0);
      chk("c_count", 32'(commit_count), 3 + HDR);
      step();
      @(negedge clk);
      chk("c_pulse_late", 32'(pkt_avail), 0);
      chk("c_count_late", 32'(commit_count), 3 + HDR);

      // Read request during a data write is deferred by one cycle
      step(); clr(); wr_start = 1'b1;
      step(); clr(); wr_en = 1'b1; wr_data = 16'h0D00; rd_force = 1'b1;
      @(negedge clk);
      chk("d_we", 32'(mem_we), 1);
      chk("d_re_blocked", 32'(mem_re), 0);
      step(); clr();
      @(negedge clk);
      chk("d_re_granted", 32'(mem_re), 1);
      chk("d_we_idle", 32'(mem_we), 0);
      step(); clr(); rd_force = 1'b0; wr_abort = 1'b1;
      @(negedge clk);
      chk("d_rd_valid", 32'(rd_valid), 1);
      step(); clr();
      drain();

      // Requests while empty are ignored
      rd_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("e_empty_re", 32'(mem_re), 0);
      end
      rd_force = 1'b0;

      // Overflow: fill all DEPTH words, one more, commit -> dropped
      do_reset();
      step(); clr(); wr_start = 1'b1;
      for (int i = 0; i < DEPTH - HDR; i++) begin
         step(); clr(); wr_en = 1'b1; wr_data = 16'hF000 + 16'(i);
      end
      step(); clr();
      @(negedge clk);
      chk("f_full", 32'(full), 1);
      chk("f_afull", 32'(almost_full), 1);
      chk("f_count_spec", 32'(commit_count), 0);
      step(); clr(); wr_en = 1'b1; wr_data = 16'hFFFF;
      step(); clr(); wr_commit = 1'b1;
      step(); clr();
      exp_ovf++;
      @(negedge clk);
      chk("f_ovf_drop", 32'(ovf_drop), 1);
      chk("f_no_pulse", 32'(pkt_avail), 0);
      chk("f_empty", 32'(empty), 1);
      chk("f_count", 32'(commit_count), 0);
      chk("f_full_clr", 32'(full), 0);
      chk("f_busy", 32'(wr_busy), 0);
      step();
      @(negedge clk);
      chk("f_ovf_1cyc", 32'(ovf_drop), 0);

      // Wrap across address 15 -> 0
      do_reset();
      send_pkt(12 - HDR, 16'h5000, 1'b0, 0);
      drain();
      send_pkt(8 - HDR, 16'h6000, 1'b0, 0);
`ifdef PKT_LEN_HEADER_EN
      step();
`endif
      @(negedge clk);
      chk("g_count", 32'(commit_count), 8);
      drain();

      // Random packets with a concurrent random reader
      rd_rand = 1'b1;
      for (int p = 0; p < 150; p++) begin
         n = $urandom_range(0, 6);
         r = $urandom_range(0, 9);
         k = 0;
         while (exp_q.size() + n + HDR > DEPTH && k < 500) begin
            step();
            k++;
         end
         if (k >= 500) begin
            tests++;
            fails++;
            $display("FAIL fit_timeout: got %0d queued words, expected room for %0d", exp_q.size(), n + HDR);
         end
         send_pkt(n, '0, 1'b1, (r < 6) ? 0 : (r < 8) ? 1 : 2);
      end
      rd_rand = 1'b0;
      drain();
      @(negedge clk);
      chk("h_count", 32'(commit_count), 0);
      chk("h_empty", 32'(empty), 1);
      step(); step();
      chk("pulse_total", 32'(n_pulse), 32'(exp_pulse));
      chk("ovf_total", 32'(n_ovf), 32'(exp_ovf));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
